// File: rtl/am_demod.sv
// am_demod: envelope-detecting AM demodulator with a windowed modulation-depth meter.
// Rectify -> envelope IIR -> DC-removal IIR -> x2 saturate; depth = (max-min)/(max+min) per window.
module am_demod #(
    parameter int unsigned ENV_SHIFT = 4,
    parameter int unsigned DC_SHIFT  = 12,
    parameter int unsigned WIN_LEN   = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sig_in,
    input  logic        in_valid,
    output logic [15:0] sig_out,
    output logic        out_valid,
    output logic [3:0]  ma_out,
    output logic        ma_valid
);
    localparam int unsigned EW  = 15 + ENV_SHIFT;
    localparam int unsigned ESW = EW + 1;
    localparam int unsigned DW  = 15 + DC_SHIFT;
    localparam int unsigned DSW = DW + 1;
    localparam int unsigned CW  = $clog2(WIN_LEN);
    localparam logic signed [17:0] SAT_HI = 18'sd32767;
    localparam logic signed [17:0] SAT_LO = -18'sd32768;

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

    // Stage 1 combinational: offset binary to two's complement, then magnitude
    logic [15:0] s;
    logic [14:0] rect;
    assign s    = {~sig_in[15], sig_in[14:0]};
    assign rect = s[15] ? ((s == 16'h8000) ? 15'h7FFF : 15'(-s)) : s[14:0];

    logic [14:0]   rect_q;
    logic          v1, v2, v3;
    logic [EW-1:0] env_acc;
    logic [14:0]   env;
    logic [DW-1:0] dc_acc;
    logic [14:0]   env_d;
    logic [14:0]   trk_max, trk_min;
    logic [CW-1:0] win_cnt;

    logic [ESW-1:0] env_sum;
    logic [14:0]    env_new;
    logic [DSW-1:0] dc_sum;
    logic [14:0]    dc;
    logic [17:0]    diff;
    logic signed [17:0] d2;
    logic [15:0]    d_sat;
    logic           latch;
    logic [14:0]    win_max, win_min;

    assign env_sum = ESW'(env_acc) + ESW'(rect_q) - ESW'(env_acc >> ENV_SHIFT);
    assign env_new = 15'(env_sum >> ENV_SHIFT);
    assign dc_sum  = DSW'(dc_acc) + DSW'(env) - DSW'(dc_acc >> DC_SHIFT);
    assign dc      = 15'(dc_acc >> DC_SHIFT);
    assign diff    = ({3'b000, env_d} - {3'b000, dc}) << 1;
    assign d2      = signed'(diff);
    assign d_sat   = (d2 > SAT_HI) ? 16'h7FFF : (d2 < SAT_LO) ? 16'h8000 : d2[15:0];

    // Window extremes include the sample that closes the window
    assign win_max = (env_new > trk_max) ? env_new : trk_max;
    assign win_min = (env_new < trk_min) ? env_new : trk_min;
    assign latch   = v1 && (win_cnt == CW'(WIN_LEN - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rect_q    <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            env_acc   <= '0;
            env       <= '0;
            dc_acc    <= '0;
            env_d     <= '0;
            trk_max   <= '0;
            trk_min   <= 15'h7FFF;
            win_cnt   <= '0;
            sig_out   <= 16'h8000;
            out_valid <= 1'b0;
        end else begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            out_valid <= v3;
            if (in_valid) rect_q <= rect;
            if (v1) begin
                env_acc <= EW'(env_sum);
                env     <= env_new;
                win_cnt <= win_cnt + 1'b1;
                if (latch) begin
                    trk_max <= '0;
                    trk_min <= 15'h7FFF;
                end else begin
                    trk_max <= win_max;
                    trk_min <= win_min;
                end
            end
            if (v2) begin
                dc_acc <= DW'(dc_sum);
                env_d  <= env;
            end
            if (v3) sig_out <= {~d_sat[15], d_sat[14:0]};
        end
    end

    // Depth divider: q = floor((20*(max-min) + (max+min)) / (2*(max+min)))
    state_t      state;
    logic [14:0] lat_max, lat_min;
    logic [20:0] num;
    logic [16:0] den;
    logic [16:0] rem;
    logic [20:0] q;
    logic [4:0]  it_cnt;
    logic [15:0] sum;
    logic [14:0] dif;
    logic [17:0] rem_sh;
    logic        ge;
    logic        busy;

    assign sum    = {1'b0, lat_max} + {1'b0, lat_min};
    assign dif    = lat_max - lat_min;
    assign rem_sh = {rem, num[20]};
    assign ge     = rem_sh >= {1'b0, den};
    assign busy   = state != IDLE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            lat_max  <= '0;
            lat_min  <= '0;
            num      <= '0;
            den      <= '0;
            rem      <= '0;
            q        <= '0;
            it_cnt   <= '0;
            ma_out   <= '0;
            ma_valid <= 1'b0;
        end else begin
            ma_valid <= 1'b0;
            case (state)
                IDLE: if (latch) begin
                    lat_max <= win_max;
                    lat_min <= win_min;
                    state   <= LOAD;
                end
                LOAD: begin
                    num    <= 21'(dif) * 21'd20 + 21'(sum);
                    den    <= {sum, 1'b0};
                    rem    <= '0;
                    q      <= '0;
                    it_cnt <= '0;
                    state  <= (sum == 16'd0) ? DONE : DIV;
                end
                DIV: begin
                    rem    <= ge ? 17'(rem_sh - {1'b0, den}) : rem_sh[16:0];
                    q      <= {q[19:0], ge};
                    num    <= {num[19:0], 1'b0};
                    it_cnt <= it_cnt + 1'b1;
                    if (it_cnt == 5'd20) state <= DONE;
                end
                DONE: begin
                    ma_out   <= (q > 21'd10) ? 4'd10 : q[3:0];
                    ma_valid <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_am_demod.sv
// Self-checking bench for am_demod: directed vector table, depth windows, saturation, reset, random stream.
module tb_am_demod;
    localparam int unsigned ES = 4;
    localparam int unsigned DS = 12;
    localparam int unsigned WL = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sig_in = 16'h8000;
    logic        in_valid = 1'b0;
    logic [15:0] sig_out;
    logic        out_valid;
    logic [3:0]  ma_out;
    logic        ma_valid;

    always #5 clk = ~clk;

    am_demod #(.ENV_SHIFT(ES), .DC_SHIFT(DS), .WIN_LEN(WL)) dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .in_valid(in_valid),
        .sig_out(sig_out), .out_valid(out_valid), .ma_out(ma_out), .ma_valid(ma_valid)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(string name, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: the spec arithmetic evaluated per accepted sample
    longint m_env_acc, m_dc_acc;
    int win_env[$];
    int exp_sig[$];
    int exp_ma[$];

    function automatic int depth(int mx, int mn);
        int sm, qq;
        sm = mx + mn;
        if (sm == 0) return 0;
        qq = (20 * (mx - mn) + sm) / (2 * sm);
        return (qq > 10) ? 10 : qq;
    endfunction

    function automatic void model_reset();
        m_env_acc = 0;
        m_dc_acc  = 0;
        win_env.delete();
        exp_sig.delete();
        exp_ma.delete();
    endfunction

    function automatic void model_push(logic [15:0] x);
        int s, r, mx, mn;
        longint env, dc, d;
        s = int'(x) - 32768;
        r = (s < 0) ? -s : s;
        if (r > 32767) r = 32767;
        m_env_acc = m_env_acc + r - (m_env_acc >> ES);
        env = m_env_acc >> ES;
        m_dc_acc = m_dc_acc + env - (m_dc_acc >> DS);
        dc = m_dc_acc >> DS;
        d = 2 * (env - dc);
        if (d > 32767) d = 32767;
        if (d < -32768) d = -32768;
        exp_sig.push_back(int'(d + 32768));
        win_env.push_back(int'(env));
        if (win_env.size() == WL) begin
            mx = 0;
            mn = 32767;
            foreach (win_env[i]) begin
                if (win_env[i] > mx) mx = win_env[i];
                if (win_env[i] < mn) mn = win_env[i];
            end
            exp_ma.push_back(depth(mx, mn));
            win_env.delete();
        end
    endfunction

    // Monitor
    int cyc = 0, out_cnt = 0, ma_cnt = 0;
    int ma_vals[$];
    int ma_times[$];
    bit sil_on = 0, sat_on = 0, sat_fall = 0;
    int sil_bad = 0, sat_bad = 0, sat_prev = 32768, sat_peak = 0;

    always @(negedge clk) begin
        cyc++;
        if (out_valid) begin
            out_cnt++;
            if (exp_sig.size() == 0) begin
                n_chk++;
                $display("FAIL sig_unexpected: got sig_out=%0h with no sample pending", sig_out);
            end else check("sig_out", sig_out, exp_sig.pop_front());
            if (sil_on && sig_out != 16'h8000) sil_bad++;
            if (sat_on) begin
                if (sig_out < 16'h8000) sat_bad++;
                if (sat_fall && int'(sig_out) > sat_prev) sat_bad++;
                if (int'(sig_out) < sat_prev) sat_fall = 1;
                if (int'(sig_out) > sat_peak) sat_peak = int'(sig_out);
                sat_prev = int'(sig_out);
            end
        end
        if (ma_valid) begin
            ma_cnt++;
            ma_vals.push_back(int'(ma_out));
            ma_times.push_back(cyc);
            if (exp_ma.size() == 0) begin
                n_chk++;
                $display("FAIL ma_unexpected: got ma_out=%0d with no window pending", ma_out);
            end else check("ma_out", ma_out, exp_ma.pop_front());
        end
        if (rst_n && dut.latch) check("latch_while_busy", dut.busy, 0);
    end

    task automatic drive(logic [15:0] x, logic v);
        @(posedge clk);
        #1;
        sig_in   = x;
        in_valid = v;
        if (v) model_push(x);
    endtask

    task automatic idle(int n);
        repeat (n) drive(16'h8000, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sig_in   = 16'h8000;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("rst_sig_out", sig_out, 16'h8000);
        check("rst_out_valid", out_valid, 0);
        check("rst_ma_out", ma_out, 0);
        check("rst_ma_valid", ma_valid, 0);
        rst_n = 1'b1;
    endtask

    task automatic depth_run(int hi, int lo, int nwin, int exp_last, string name);
        int a;
        logic [15:0] x;
        do_reset();
        ma_vals.delete();
        for (int i = 0; i < nwin * int'(WL); i++) begin
            a = (((i / 512) % 2) == 0) ? hi : lo;
            x = ((i % 2) == 0) ? 16'(32768 + a) : 16'(32768 - a);
            drive(x, 1'b1);
        end
        idle(40);
        check({name, "_count"}, ma_vals.size(), nwin);
        if (ma_vals.size() == nwin) begin
            for (int w = 1; w < nwin; w++) check(name, ma_vals[w], exp_last);
        end
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        // First output after reset: env = rect >> ES, dc = 0, sig_out = 0x8000 + 2*env
        tbl[0] = '{16'h8000, 16'h8000};
        tbl[1] = '{16'h0000, 16'h8FFE};
        tbl[2] = '{16'hFFFF, 16'h8FFE};
        tbl[3] = '{16'h8010, 16'h8002};
        tbl[4] = '{16'h7FF0, 16'h8002};
        tbl[5] = '{16'h800F, 16'h8000};
        tbl[6] = '{16'hC000, 16'h8800};
        tbl[7] = '{16'h4000, 16'h8800};

        model_reset();
        for (int i = 0; i < 8; i++) begin
            do_reset();
            drive(tbl[i].x, 1'b1);
            drive(16'h8000, 1'b0);
            repeat (3) begin
                @(negedge clk);
                check("latency_early", out_valid, 0);
            end
            @(negedge clk);
            check("latency_strobe", out_valid, 1);
            check("first_sample", sig_out, tbl[i].exp);
            @(negedge clk);
            check("strobe_width", out_valid, 0);
        end

        // Throughput: continuous then every other cycle
        do_reset();
        out_cnt = 0;
        for (int i = 0; i < 100; i++) drive(16'($urandom), 1'b1);
        idle(10);
        check("burst_count", out_cnt, 100);
        out_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            drive(16'($urandom), 1'b1);
            drive(16'($urandom), 1'b0);
        end
        idle(10);
        check("toggle_count", out_cnt, 50);

        // Silence: D = 0 path, two pulses one window apart
        do_reset();
        ma_vals.delete();
        ma_times.delete();
        sil_on = 1;
        for (int i = 0; i < 2 * int'(WL); i++) drive(16'h8000, 1'b1);
        idle(40);
        sil_on = 0;
        check("silence_sig", sil_bad, 0);
        check("silence_ma_count", ma_vals.size(), 2);
        if (ma_vals.size() == 2) begin
            check("silence_ma0", ma_vals[0], 0);
            check("silence_ma1", ma_vals[1], 0);
            check("silence_spacing", ma_times[1] - ma_times[0], WL);
        end

        // Saturation: full-scale input, envelope pins at 32767, output never wraps
        do_reset();
        sat_on = 1; sat_fall = 0; sat_prev = 32768; sat_peak = 0; sat_bad = 0;
        for (int i = 0; i < 20 * (1 << ES); i++) drive(16'h0000, 1'b1);
        idle(3);
        check("env_saturated", (dut.env >= 15'd32766) ? 1 : 0, 1);
        for (int i = 0; i < 4500; i++) drive(16'h0000, 1'b1);
        idle(10);
        sat_on = 0;
        check("sat_no_wrap", sat_bad, 0);
        check("sat_peak", sat_peak, 16'hFFFF);
        check("sat_decays", sat_fall, 1);

        // Depth windows
        depth_run(24000, 8000, 3, 5, "depth_half");
        depth_run(30000, 0, 2, 10, "depth_clamp");
        depth_run(20000, 10000, 2, 3, "depth_third");

        // Reset mid-divide: no stale ma_valid afterwards
        do_reset();
        for (int i = 0; i < int'(WL) + 8; i++) drive(16'($urandom), 1'b1);
        do_reset();
        ma_cnt = 0;
        idle(50);
        check("no_stale_ma", ma_cnt, 0);

        // Reset mid-window with random valid, then a clean random run
        for (int i = 0; i < 2000; i++) drive(16'($urandom), ($urandom_range(0, 3) != 0));
        do_reset();
        for (int i = 0; i < 3000; i++) drive(16'($urandom), ($urandom_range(0, 3) != 0));
        idle(40);
        check("sig_queue_empty", exp_sig.size(), 0);
        check("ma_queue_empty", exp_ma.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/am_demod.md
Name: am_demod

Overview:
- Receive-side counterpart of the DDS AM modulator: takes offset-binary AM samples and recovers the modulating signal by envelope detection.
- Measures the modulation depth over a fixed sample window and reports it on the same 1..10 scale (x0.1) the modulator's ma input uses.
- Sits after the ADC/loopback sample path and feeds the display and measurement logic.

Parameters:
- ENV_SHIFT, 4, envelope IIR time constant (alpha = 2^-ENV_SHIFT); legal 2..8.
- DC_SHIFT, 12, DC-removal IIR time constant; must be greater than ENV_SHIFT.
- WIN_LEN, 4096, valid samples per depth-measurement window; power of two, at least 64.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- sig_in  in  16  AM sample, offset binary (0x8000 = zero)
- in_valid  in  1  sig_in qualifier; may be high every cycle
- sig_out  out  16  recovered modulating signal, offset binary
- out_valid  out  1  one-cycle strobe per recovered sample
- ma_out  out  4  measured depth, 0..10 (x0.1)
- ma_valid  out  1  one-cycle strobe when ma_out updates

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values, sampled on a clk edge with rst_n low:
  - sig_out = 0x8000; out_valid = 0; ma_out = 0; ma_valid = 0.
  - Envelope and DC accumulators, window counter, max/min registers cleared; divider FSM forced to IDLE.
  - Reset mid-division abandons the result and no ma_valid is issued.
- Stage 1, register on in_valid:
  - s = {~sig_in[15], sig_in[14:0]} (signed).
  - rect = |s|, with -32768 saturating to 32767 (16-bit unsigned, bit 15 always 0).
- Stage 2, envelope:
  - env_acc has width 15+ENV_SHIFT bits.
  - env_acc <= env_acc + rect - (env_acc >> ENV_SHIFT); env = env_acc >> ENV_SHIFT (15 bits).
- Stage 3, DC removal:
  - dc_acc <= dc_acc + env - (dc_acc >> DC_SHIFT); dc = dc_acc >> DC_SHIFT.
  - d = 2*(env - dc), saturated to [-32768, 32767]; sig_out = d + 0x8000.
- Latency and strobes:
  - A sample with in_valid high at edge N gives out_valid high for exactly the cycle after edge N+3.
  - Pipeline stages advance only on valid; there are no bubbles between back-to-back samples.
  - No backpressure.
- Depth window:
  - On each stage-2 update, track env_max and env_min (env_min initialised to 0x7FFF at window start).
  - The WIN_LEN-th update latches max/min into the divider and restarts tracking with the next sample.
  - The window counter wraps with no gap.
- Divider FSM:
  - IDLE: waits for a latch.
  - LOAD: N = 20*(max-min) + (max+min); D = 2*(max+min); if D = 0, go to DONE with q = 0.
  - DIV: 21-iteration restoring divide, one quotient bit per cycle.
  - DONE: ma_out = min(q, 10), ma_valid high for 1 cycle, return to IDLE.
  - Total LOAD to ma_valid is 23 cycles or fewer. Because WIN_LEN is at least 64, the divider is always idle before the next latch.
  - A latch while busy is impossible by construction; the bench asserts this.
- Arithmetic: all widths sized so no intermediate overflows; saturation occurs only where stated.

Test Plan:
- Reset: run a random stream, pull rst_n low for 3 cycles mid-window and mid-divide -> next cycle sig_out = 0x8000, out_valid = 0, ma_out = 0, ma_valid = 0; no stale ma_valid after release.
- Latency/throughput: in_valid high continuously for 100 samples -> exactly 100 out_valid pulses, first one 3 cycles after the first sample. With in_valid toggling every other cycle -> one out_valid per accepted sample.
- Silence: constant 0x8000 for 2*WIN_LEN samples -> sig_out = 0x8000 throughout; two ma_valid pulses WIN_LEN samples apart, each with ma_out = 0 (D = 0 path).
- Saturation: constant 0x0000 -> rect = 32767 each sample, env reaches 32767 within 1 LSB after 20*2^ENV_SHIFT samples; sig_out never wraps (stays in 0x8000..0xFFFF, monotonic rise then decay).
- Depth 0.5: carrier alternating +A/-A every sample, A toggling 24000/8000 every 512 samples -> from the second window on, ma_out = 5 on every ma_valid.
- Depth clamp: A toggling 30000/0 every 512 samples -> ma_out = 10; a directed divider check with max = 20000, min = 10000 gives ma_out = 3 (3.33 rounded).
